// File: rtl/execute_stage.sv
// Execute stage of a Y86-64 style pipeline: operand selection, ALU, condition codes,
// condition evaluation for cmov/jump, and the M pipeline register.
module execute_stage #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] SAOK  = 4'h1,
  parameter logic [3:0] SHLT  = 4'h2,
  parameter logic [3:0] SADR  = 4'h3,
  parameter logic [3:0] SINS  = 4'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [3:0]  E_stat,
  input  logic [3:0]  E_destE,
  input  logic [3:0]  E_destM,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valC,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  input  logic        M_bubble,
  output logic [63:0] e_valE,
  output logic [3:0]  e_destE,
  output logic        e_Cnd,
  output logic        ZF,
  output logic        SF,
  output logic        OF,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_destE,
  output logic [3:0]  M_destM,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic        M_Cnd
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [63:0] MINUS8 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] PLUS8  = 64'h0000_0000_0000_0008;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_res;
  logic [3:0]  alu_fun;
  logic        new_zf;
  logic        new_sf;
  logic        new_of;
  logic        set_cc;
  logic        less;

  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:            alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:            alu_a = MINUS8;
      I_RET, I_POPQ:              alu_a = PLUS8;
      default:                    alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                  alu_b = '0;
    endcase
  end

  assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

  always_comb begin
    alu_res = '0;
    new_of  = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        alu_res = alu_b + alu_a;
        new_of  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
      end
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        new_of  = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
      end
      ALU_AND: alu_res = alu_b & alu_a;
      ALU_XOR: alu_res = alu_b ^ alu_a;
      default: alu_res = '0;
    endcase
  end

  assign new_zf = (alu_res == 64'd0);
  assign new_sf = alu_res[63];
  assign e_valE = alu_res;

  // Flags must not change while a faulting instruction is further down the pipe.
  assign set_cc = (E_icode == I_OPQ)
               && !(m_stat == SHLT || m_stat == SADR || m_stat == SINS)
               && !(W_stat == SHLT || W_stat == SADR || W_stat == SINS);

  assign less = SF ^ OF;

  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      4'h0:    e_Cnd = 1'b1;
      4'h1:    e_Cnd = less | ZF;
      4'h2:    e_Cnd = less;
      4'h3:    e_Cnd = ZF;
      4'h4:    e_Cnd = ~ZF;
      4'h5:    e_Cnd = ~less;
      4'h6:    e_Cnd = ~less & ~ZF;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_destE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_destE;

  always_ff @(posedge clk) begin
    if (rst) begin
      ZF <= 1'b1;
      SF <= 1'b0;
      OF <= 1'b0;
    end else if (set_cc) begin
      ZF <= new_zf;
      SF <= new_sf;
      OF <= new_of;
    end
  end

  // Reset and bubble both leave a harmless nop in the M stage.
  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      M_icode <= I_NOP;
      M_stat  <= SAOK;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_destE <= RNONE;
      M_destM <= RNONE;
    end else begin
      M_icode <= E_icode;
      M_stat  <= E_stat;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_destE <= e_destE;
      M_destM <= E_destM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios followed by randomized
// stimulus, all compared against an arithmetic reference model of the Y86-64 execute rules.
module tb_execute_stage;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] SMIN = -SMAX - 65'sd1;

  logic        clk;
  logic        rst;
  logic [3:0]  E_icode, E_ifun, E_stat, E_destE, E_destM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [3:0]  m_stat, W_stat;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_destE;
  logic        e_Cnd;
  logic        ZF, SF, OF;
  logic [3:0]  M_icode, M_stat, M_destE, M_destM;
  logic [63:0] M_valE, M_valA;
  logic        M_Cnd;

  int cmpCount = 0;
  int errCount = 0;

  // Reference model state
  logic        modelValid = 1'b0;
  logic        mZF, mSF, mOF;
  logic [3:0]  mIcode, mStat, mDestE, mDestM;
  logic [63:0] mValE, mValA;
  logic        mCnd;
  logic [63:0] expValE;
  logic        expCnd, expSetCc, nZF, nSF, nOF;
  logic [3:0]  expDestE;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat), .E_destE(E_destE), .E_destM(E_destM),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_destE(e_destE), .e_Cnd(e_Cnd),
    .ZF(ZF), .SF(SF), .OF(OF),
    .M_icode(M_icode), .M_stat(M_stat), .M_destE(M_destE), .M_destM(M_destM),
    .M_valE(M_valE), .M_valA(M_valA), .M_Cnd(M_Cnd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmpCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic isFault(input logic [3:0] s);
    return (s == 4'h2) || (s == 4'h3) || (s == 4'h4);
  endfunction

  // Signed 65-bit arithmetic: overflow is simply "true result outside the 64-bit signed range".
  task automatic refExec(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         output logic [63:0] res, output logic zf, output logic sf, output logic of);
    logic signed [64:0] wide;
    res = 64'd0;
    of = 1'b0;
    case (icode)
      4'h2: res = a;
      4'h3: res = c;
      4'h4, 4'h5: res = b + c;
      4'h8, 4'hA: res = b - 64'd8;
      4'h9, 4'hB: res = b + 64'd8;
      4'h6: begin
        case (ifun)
          4'h0: begin
            wide = $signed({a[63], a}) + $signed({b[63], b});
            res = wide[63:0];
            of = (wide > SMAX) || (wide < SMIN);
          end
          4'h1: begin
            wide = $signed({b[63], b}) - $signed({a[63], a});
            res = wide[63:0];
            of = (wide > SMAX) || (wide < SMIN);
          end
          4'h2: res = a & b;
          4'h3: res = a ^ b;
          default: res = 64'd0;
        endcase
      end
      default: res = 64'd0;
    endcase
    zf = (res == 64'd0);
    sf = res[63];
  endtask

  function automatic logic refCond(input logic [3:0] ifun, input logic zf, input logic sf, input logic of);
    logic signedLess;
    signedLess = sf ^ of;
    case (ifun)
      4'h0: return 1'b1;
      4'h1: return signedLess || zf;
      4'h2: return signedLess;
      4'h3: return zf;
      4'h4: return !zf;
      4'h5: return !signedLess;
      4'h6: return !signedLess && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Drives one E-stage instruction, predicts everything and checks the combinational outputs.
  task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] ifun, input logic [3:0] stat,
                               input logic [3:0] destE, input logic [3:0] destM,
                               input logic [63:0] valA, input logic [63:0] valB, input logic [63:0] valC,
                               input logic [3:0] mSt, input logic [3:0] wSt,
                               input logic bubble, input logic rstIn);
    E_icode = icode; E_ifun = ifun; E_stat = stat; E_destE = destE; E_destM = destM;
    E_valA = valA; E_valB = valB; E_valC = valC;
    m_stat = mSt; W_stat = wSt; M_bubble = bubble; rst = rstIn;
    refExec(icode, ifun, valA, valB, valC, expValE, nZF, nSF, nOF);
    expCnd = refCond(ifun, mZF, mSF, mOF);
    expDestE = (icode == 4'h2 && !expCnd) ? RNONE : destE;
    expSetCc = (icode == 4'h6) && !isFault(mSt) && !isFault(wSt);
    #2;
    checkOutput("e_valE", e_valE, expValE);
    if (modelValid) begin
      checkOutput("e_Cnd", 64'(e_Cnd), 64'(expCnd));
      checkOutput("e_destE", 64'(e_destE), 64'(expDestE));
    end
  endtask

  // Advances one edge, updates the model and checks all registered outputs.
  task automatic stepClock();
    @(posedge clk);
    #1;
    if (rst) begin
      mZF = 1'b1; mSF = 1'b0; mOF = 1'b0;
      modelValid = 1'b1;
    end else if (expSetCc) begin
      mZF = nZF; mSF = nSF; mOF = nOF;
    end
    if (rst || M_bubble) begin
      mIcode = 4'h1; mStat = 4'h1; mCnd = 1'b0; mValE = 64'd0; mValA = 64'd0;
      mDestE = RNONE; mDestM = RNONE;
    end else begin
      mIcode = E_icode; mStat = E_stat; mCnd = expCnd; mValE = expValE; mValA = E_valA;
      mDestE = expDestE; mDestM = E_destM;
    end
    checkOutput("ZF", 64'(ZF), 64'(mZF));
    checkOutput("SF", 64'(SF), 64'(mSF));
    checkOutput("OF", 64'(OF), 64'(mOF));
    checkOutput("M_icode", 64'(M_icode), 64'(mIcode));
    checkOutput("M_stat", 64'(M_stat), 64'(mStat));
    checkOutput("M_Cnd", 64'(M_Cnd), 64'(mCnd));
    checkOutput("M_valE", M_valE, mValE);
    checkOutput("M_valA", M_valA, mValA);
    checkOutput("M_destE", 64'(M_destE), 64'(mDestE));
    checkOutput("M_destM", 64'(M_destM), 64'(mDestM));
  endtask

  function automatic logic [63:0] randVal();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic logic [3:0] randStat();
    if ($urandom_range(0, 3) != 0) return 4'h1;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    mZF = 1'b0; mSF = 1'b0; mOF = 1'b0;
    mIcode = 4'h0; mStat = 4'h0; mDestE = 4'h0; mDestM = 4'h0;
    mValE = 64'd0; mValA = 64'd0; mCnd = 1'b0;

    // Reset
    applyStimulus(4'h6, 4'h0, 4'h1, 4'h3, RNONE, 64'd9, 64'd9, 64'd0, 4'h1, 4'h1, 1'b0, 1'b1);
    stepClock();
    checkOutput("rst_M_icode", 64'(M_icode), 64'h1);
    checkOutput("rst_M_destM", 64'(M_destM), 64'hF);
    checkOutput("rst_ZF", 64'(ZF), 64'h1);

    // OPq sub equal operands
    applyStimulus(4'h6, 4'h1, 4'h1, 4'h3, RNONE, 64'd5, 64'd5, 64'd0, 4'h1, 4'h1, 1'b0, 1'b0);
    checkOutput("sub_valE", e_valE, 64'd0);
    stepClock();
    checkOutput("sub_ZF", 64'(ZF), 64'h1);
    checkOutput("sub_M_destE", 64'(M_destE), 64'h3);

    // OPq add overflow
    applyStimulus(4'h6, 4'h0, 4'h1, 4'h2, RNONE, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'd0, 4'h1, 4'h1, 1'b0, 1'b0);
    checkOutput("add_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    stepClock();
    checkOutput("add_OF", 64'(OF), 64'h1);
    checkOutput("add_SF", 64'(SF), 64'h1);

    // Establish ZF=0 SF=1 OF=0, then cmovle / cmove
    applyStimulus(4'h6, 4'h1, 4'h1, 4'h2, RNONE, 64'd5, 64'd3, 64'd0, 4'h1, 4'h1, 1'b0, 1'b0);
    stepClock();
    applyStimulus(4'h2, 4'h1, 4'h1, 4'h4, RNONE, 64'd77, 64'd0, 64'd0, 4'h1, 4'h1, 1'b0, 1'b0);
    checkOutput("cmovle_Cnd", 64'(e_Cnd), 64'h1);
    checkOutput("cmovle_destE", 64'(e_destE), 64'h4);
    stepClock();
    applyStimulus(4'h2, 4'h3, 4'h1, 4'h4, RNONE, 64'd77, 64'd0, 64'd0, 4'h1, 4'h1, 1'b0, 1'b0);
    checkOutput("cmove_Cnd", 64'(e_Cnd), 64'h0);
    checkOutput("cmove_destE", 64'(e_destE), 64'hF);
    stepClock();
    checkOutput("cmove_M_destE", 64'(M_destE), 64'hF);

    // Flag update suppressed by faulting later-stage instructions
    applyStimulus(4'h6, 4'h3, 4'h1, 4'h5, RNONE, 64'd7, 64'd7, 64'd0, 4'h3, 4'h1, 1'b0, 1'b0);
    stepClock();
    checkOutput("xor_madr_ZF", 64'(ZF), 64'h0);
    applyStimulus(4'h6, 4'h3, 4'h1, 4'h5, RNONE, 64'd7, 64'd7, 64'd0, 4'h1, 4'h2, 1'b0, 1'b0);
    stepClock();
    checkOutput("xor_whlt_ZF", 64'(ZF), 64'h0);
    applyStimulus(4'h6, 4'h3, 4'h1, 4'h5, RNONE, 64'd7, 64'd7, 64'd0, 4'h1, 4'h1, 1'b1, 1'b0);
    stepClock();
    checkOutput("xor_aok_ZF", 64'(ZF), 64'h1);

    // Stack pointer arithmetic and bubble injection
    applyStimulus(4'hA, 4'h0, 4'h1, 4'h4, RNONE, 64'd1, 64'h100, 64'd0, 4'h1, 4'h1, 1'b0, 1'b0);
    checkOutput("push_valE", e_valE, 64'hF8);
    stepClock();
    applyStimulus(4'hB, 4'h0, 4'h1, 4'h4, 4'h6, 64'd1, 64'h100, 64'd0, 4'h1, 4'h1, 1'b1, 1'b0);
    checkOutput("pop_valE", e_valE, 64'h108);
    stepClock();
    checkOutput("bubble_M_icode", 64'(M_icode), 64'h1);
    checkOutput("bubble_M_destE", 64'(M_destE), 64'hF);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] icode;
      logic [3:0] ifun;
      icode = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      ifun = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      applyStimulus(icode, ifun, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), randVal(), randVal(), randVal(),
                    randStat(), randStat(), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 39) == 0));
      stepClock();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter RNONE, default 4'hF, meaning "no register" destination code.
REQ-002 SHALL have parameter SAOK, default 4'h1, meaning status AOK; SHLT=4'h2, SADR=4'h3, SINS=4'h4 likewise.
REQ-003 SHALL have port clk  input  1  rising-edge clock for the condition-code register and M pipeline register.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports E_icode, E_ifun, E_stat, E_destE, E_destM  input  4 each  execute-stage fields from the E register.
REQ-006 SHALL have ports E_valA, E_valB, E_valC  input  64 each  operands from the E register.
REQ-007 SHALL have ports m_stat, W_stat  input  4 each  status of the memory-stage instruction and the write-back-stage instruction.
REQ-008 SHALL have port M_bubble  input  1  inject a bubble into the M register on this edge.
REQ-009 SHALL have ports e_valE  output  64, e_destE  output  4, e_Cnd  output  1  combinational forwarding outputs.
REQ-010 SHALL have ports ZF, SF, OF  output  1 each  registered condition codes.
REQ-011 SHALL have ports M_icode, M_stat, M_destE, M_destM  output  4 each; M_valE, M_valA  output  64 each; M_Cnd  output  1  registered M-stage fields.

Function
REQ-012 aluA SHALL be E_valA for icode 2 (rrmovq/cmovXX) and 6 (OPq); E_valC for 3, 4, 5; -8 for 8 (call) and A (pushq); +8 for 9 (ret) and B (popq); 0 otherwise.
REQ-013 aluB SHALL be E_valB for icodes 4, 5, 6, 8, 9, A, B; 0 for 2 and 3 and all other icodes.
REQ-014 ALU function SHALL be E_ifun when E_icode==6, else add.
REQ-015 ALU ops: ifun 0 aluB+aluA; 1 aluB-aluA; 2 aluB AND aluA; 3 aluB XOR aluA; other ifun with icode 6 yields 0; all 64-bit, wrap modulo 2^64.
REQ-016 e_valE SHALL equal the ALU result, combinationally.
REQ-017 New flags: ZF'=(result==0); SF'=result[63]; OF' add=(aluA[63]==aluB[63])&&(result[63]!=aluA[63]); sub=(aluA[63]!=aluB[63])&&(result[63]!=aluB[63]); and/xor=0.
REQ-018 set_cc SHALL be true only when E_icode==6 and neither m_stat nor W_stat is in {SHLT, SADR, SINS}.
REQ-019 ZF/SF/OF SHALL load ZF'/SF'/OF' on a rising edge when set_cc is true and rst is low; else hold.
REQ-020 e_Cnd SHALL be computed from the currently registered flags (not the flags being produced this cycle): ifun 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7-F 0.
REQ-021 e_destE SHALL be RNONE when E_icode==2 and e_Cnd==0, else E_destE.
REQ-022 On a rising edge with rst low and M_bubble low, M register SHALL capture: M_icode=E_icode, M_stat=E_stat, M_Cnd=e_Cnd, M_valE=e_valE, M_valA=E_valA, M_destE=e_destE, M_destM=E_destM.
REQ-023 On a rising edge with M_bubble high and rst low, M register SHALL load the bubble: icode 4'h1, stat SAOK, destE/destM RNONE, valE/valA 0, Cnd 0.
REQ-024 Latency: one cycle from E inputs to M outputs; flags visible to e_Cnd the cycle after the OPq is in execute.
REQ-025 M_bubble SHALL NOT inhibit the CC update; only set_cc gates it.

Reset
REQ-026 On a rising edge with rst high, M register SHALL load the bubble values of REQ-023, overriding M_bubble.
REQ-027 On a rising edge with rst high, flags SHALL become ZF=1, SF=0, OF=0, overriding set_cc.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight M contents within that one edge; combinational outputs continue to follow E inputs.

Verification
REQ-029 Reset 1 cycle -> M_icode=1, M_stat=1, M_destE=M_destM=F, M_valE=M_valA=0, M_Cnd=0, ZF=1 SF=0 OF=0.
REQ-030 OPq sub, valA=5, valB=5, destE=3 -> e_valE=0; next edge ZF=1 SF=0 OF=0, M_valE=0, M_destE=3.
REQ-031 OPq add, valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> e_valE=64'hFFFF_FFFF_FFFF_FFFE; next edge SF=1 OF=1 ZF=0.
REQ-032 With ZF=0, SF=1, OF=0: cmovle (icode 2 ifun 1) destE=4 -> e_Cnd=1, e_destE=4; cmove (ifun 3) -> e_Cnd=0, e_destE=F, M_destE=F next edge.
REQ-033 OPq xor producing 0 with m_stat=SADR -> flags unchanged after edge; same with W_stat=SHLT -> flags unchanged; with both AOK -> ZF=1.
REQ-034 pushq valB=64'h100 -> e_valE=64'hF8; popq valB=64'h100 -> e_valE=64'h108; with M_bubble=1 on that edge -> M_icode=1, M_destE=F.
